// File: rtl/noc_inject_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// noc_inject_arbiter_pkg
//   Shared NoC parameters and types for the local injection arbiter and the
//   round-robin arbiter it uses.
//   Contents:
//     Noc_VC_Channel / Noc_Data_Width : output-port VC count and payload width
//     NOC_FLIT_W                      : default flit width {is_header, is_tail, payload}
//     FLIT_HDR_BIT / FLIT_TAIL_BIT    : marker bit positions for the default flit
//     inj_state_e                     : injection FSM state encoding
// -----------------------------------------------------------------------------
package noc_inject_arbiter_pkg;

  localparam int Noc_VC_Channel = 4;
  localparam int Noc_Data_Width = 32;

  localparam int NOC_FLIT_W    = Noc_Data_Width + 2;
  localparam int FLIT_HDR_BIT  = NOC_FLIT_W - 1;
  localparam int FLIT_TAIL_BIT = NOC_FLIT_W - 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FWD  = 1'b1
  } inj_state_e;

endpackage

// File: rtl/noc_inject_arbiter_if.sv
// -----------------------------------------------------------------------------
// noc_inject_arbiter_if
//   Bundle of the flit-level signals between the local sources, the injection
//   arbiter and the router local input port.
//   Signals:
//     src_valid [NUM_SRC]         per-source flit valid
//     src_flit  [NUM_SRC*FLIT_W]  per-source flit, source i at [i*FLIT_W +: FLIT_W]
//     src_ready [NUM_SRC]         per-source accept (a flit moves when valid & ready)
//     out_valid [VC_NUM]          one-hot (or zero) flit valid toward the router
//     out_flit  [FLIT_W]          flit toward the router, shared by all VCs
//     out_ready [VC_NUM]          per-VC router ready
//   Modports:
//     master : sources + router side (drives valids/flits in, ready out)
//     slave  : the arbiter
//
//   Handshake: a flit transfers on a rising clock edge exactly when valid and
//   ready are both high in the cycle before it. A source keeps valid and flit
//   stable until it is accepted; the arbiter keeps out_valid/out_flit stable
//   until the selected VC's out_ready is seen high.
// -----------------------------------------------------------------------------
interface noc_inject_arbiter_if
  import noc_inject_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int VC_NUM  = Noc_VC_Channel,
  parameter int FLIT_W  = NOC_FLIT_W
);

  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*FLIT_W-1:0] src_flit;
  logic [NUM_SRC-1:0]        src_ready;
  logic [VC_NUM-1:0]         out_valid;
  logic [FLIT_W-1:0]         out_flit;
  logic [VC_NUM-1:0]         out_ready;

  modport master (
    output src_valid,
    output src_flit,
    output out_ready,
    input  src_ready,
    input  out_valid,
    input  out_flit
  );

  modport slave (
    input  src_valid,
    input  src_flit,
    input  out_ready,
    output src_ready,
    output out_valid,
    output out_flit
  );

endinterface

// File: rtl/noc_rr_arbiter.sv
// -----------------------------------------------------------------------------
// noc_rr_arbiter
//   Combinational round-robin arbiter. The search starts at index ptr and
//   wraps; the first requester found wins.
//   Ports:
//     req         in  [N]      request vector
//     ptr         in  [IDX_W]  highest-priority index this cycle
//     grant       out [N]      one-hot grant (zero when no request)
//     grant_idx   out [IDX_W]  index of the granted requester
//     grant_valid out          at least one request present
// -----------------------------------------------------------------------------
module noc_rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDX_W'((int'(ptr) + k) % N);
      if (!grant_valid && req[idx]) begin
        grant[idx]  = 1'b1;
        grant_idx   = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// -----------------------------------------------------------------------------
// noc_inject_arbiter
//   Packet-granular injection arbiter between NUM_SRC local flit sources and
//   one router local input port. A source is granted round-robin on a header
//   flit and keeps the grant (wormhole lock) until its tail flit is accepted.
//   One free VC is chosen per packet and used for every flit of that packet.
//   Flits pass through a single output register (1 cycle src -> out).
//
//   Ports:
//     noc_clk    in   clock
//     noc_rst_n  in   asynchronous active-low reset
//     inj        slave modport of noc_inject_arbiter_if (src_*/out_* handshakes)
//     proto_err  out  sticky: a non-header flit was offered while idle
//     pkt_cnt    out  [NUM_SRC*16] per-source tail count   (NOC_INJ_STATS_EN)
//     flit_cnt   out  [32] flits transferred to the router  (NOC_INJ_STATS_EN)
//     state_dbg  out  current FSM state
//
//   Build option: define NOC_INJ_STATS_EN to add the pkt_cnt/flit_cnt
//   statistics counters. Without it the ports and counters are absent.
// -----------------------------------------------------------------------------
module noc_inject_arbiter
  import noc_inject_arbiter_pkg::*;
#(
  parameter  int NUM_SRC = 4,
  parameter  int VC_NUM  = Noc_VC_Channel,
  parameter  int FLIT_W  = NOC_FLIT_W,
  localparam int PTR_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int VC_W    = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst_n,
  noc_inject_arbiter_if.slave   inj,
  output logic                  proto_err,
`ifdef NOC_INJ_STATS_EN
  output logic [NUM_SRC*16-1:0] pkt_cnt,
  output logic [31:0]           flit_cnt,
`endif
  output inj_state_e            state_dbg
);

  localparam int HDR_BIT  = FLIT_W - 1;
  localparam int TAIL_BIT = FLIT_W - 2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  inj_state_e         state_q, state_d;
  logic [PTR_W-1:0]   grant_q, grant_d;
  logic [NUM_SRC-1:0] grant_oh_q, grant_oh_d;
  logic [VC_W-1:0]    vc_q, vc_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [VC_NUM-1:0]  out_valid_q;
  logic [FLIT_W-1:0]  out_flit_q;
  logic               proto_err_q;

  // ---------------------------------------------------------------------------
  // Per-source flit view
  // ---------------------------------------------------------------------------
  logic [FLIT_W-1:0]  flit_arr [NUM_SRC];
  logic [NUM_SRC-1:0] hdr_vec;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign flit_arr[gi] = inj.src_flit[gi*FLIT_W +: FLIT_W];
    assign hdr_vec[gi]  = flit_arr[gi][HDR_BIT];
  end

  logic [FLIT_W-1:0] sel_flit;
  assign sel_flit = flit_arr[grant_q];

  // ---------------------------------------------------------------------------
  // Output register occupancy. The register can take a new flit when it is
  // empty or when its current flit leaves this same cycle.
  // ---------------------------------------------------------------------------
  logic reg_xfer;
  logic can_load;
  assign reg_xfer = |(out_valid_q & inj.out_ready);
  assign can_load = ~(|out_valid_q) | reg_xfer;

  // ---------------------------------------------------------------------------
  // Header arbitration and free-VC pick (lowest ready VC)
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] arb_grant;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_valid;

  noc_rr_arbiter #(.N(NUM_SRC)) u_rr_arb (
    .req         (inj.src_valid & hdr_vec),
    .ptr         (rr_ptr_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  logic [VC_W-1:0] vc_free;
  logic            vc_found;

  always_comb begin
    vc_free  = '0;
    vc_found = 1'b0;
    // Descending scan so the lowest ready index is the one left standing.
    for (int v = VC_NUM - 1; v >= 0; v--) begin
      if (inj.out_ready[v]) begin
        vc_free  = VC_W'(v);
        vc_found = 1'b1;
      end
    end
  end

  logic [VC_NUM-1:0] vc_onehot;
  assign vc_onehot = {{(VC_NUM-1){1'b0}}, 1'b1} << vc_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_oh_q <= '0;
      vc_q       <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_oh_q <= grant_oh_d;
      vc_q       <= vc_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and outputs
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] src_ready_c;
  logic               accept;
  logic               tail_accept;
  logic               err_set;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_oh_d  = grant_oh_q;
    vc_d        = vc_q;
    rr_ptr_d    = rr_ptr_q;
    src_ready_c = '0;
    accept      = 1'b0;
    tail_accept = 1'b0;
    err_set     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Nothing is accepted while idle; the cycle is spent arbitrating.
        err_set = |(inj.src_valid & ~hdr_vec);
        if (arb_valid && vc_found) begin
          grant_d    = arb_idx;
          grant_oh_d = arb_grant;
          vc_d       = vc_free;
          state_d    = FWD;
        end
      end

      FWD: begin
        // Only the locked source can move; header bits mid-packet are not
        // inspected, the flit passes through as offered.
        src_ready_c = inj.src_valid & grant_oh_q & {NUM_SRC{can_load}};
        accept      = |src_ready_c;
        tail_accept = accept & sel_flit[TAIL_BIT];
        if (tail_accept) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == PTR_W'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register and sticky error
  // ---------------------------------------------------------------------------
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      out_valid_q <= '0;
      out_flit_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (accept) begin
        out_flit_q  <= sel_flit;
        out_valid_q <= vc_onehot;
      end else if (reg_xfer) begin
        out_valid_q <= '0;
      end
      if (err_set) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  assign inj.src_ready = src_ready_c;
  assign inj.out_valid = out_valid_q;
  assign inj.out_flit  = out_flit_q;
  assign proto_err     = proto_err_q;
  assign state_dbg     = state_q;

  // ---------------------------------------------------------------------------
  // Statistics counters (wrap naturally)
  // ---------------------------------------------------------------------------
`ifdef NOC_INJ_STATS_EN
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      pkt_cnt  <= '0;
      flit_cnt <= '0;
    end else begin
      if (tail_accept) begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (grant_q == PTR_W'(i)) begin
            pkt_cnt[i*16 +: 16] <= pkt_cnt[i*16 +: 16] + 16'd1;
          end
        end
      end
      if (reg_xfer) begin
        flit_cnt <= flit_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// -----------------------------------------------------------------------------
// tb_noc_inject_arbiter
//   Directed bench for noc_inject_arbiter. Per-source flit queues feed the
//   sources; every flit expected at the router is queued in exp_q as
//   {vc, flit} and popped on each observed transfer. Directed steps check
//   timing, arbitration order, VC choice, stalls, proto_err and reset.
//   Timing: driver updates sources 1 time unit after the rising edge, directed
//   checks and out_ready changes happen 1 unit after the falling edge, and
//   transfers are sampled 1 unit before the rising edge.
// -----------------------------------------------------------------------------
module tb_noc_inject_arbiter;
  import noc_inject_arbiter_pkg::*;

  localparam int NS = 4;
  localparam int NV = Noc_VC_Channel;
  localparam int FW = NOC_FLIT_W;
  localparam int W  = 2 + FW;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic noc_clk   = 1'b0;
  logic noc_rst_n = 1'b0;
  always #5 noc_clk = ~noc_clk;

  noc_inject_arbiter_if #(.NUM_SRC(NS), .VC_NUM(NV), .FLIT_W(FW)) inj ();

  logic       proto_err;
  inj_state_e state_dbg;
`ifdef NOC_INJ_STATS_EN
  logic [NS*16-1:0] pkt_cnt;
  logic [31:0]      flit_cnt;
`endif

  noc_inject_arbiter #(.NUM_SRC(NS), .VC_NUM(NV), .FLIT_W(FW)) dut (
    .noc_clk   (noc_clk),
    .noc_rst_n (noc_rst_n),
    .inj       (inj),
    .proto_err (proto_err),
`ifdef NOC_INJ_STATS_EN
    .pkt_cnt   (pkt_cnt),
    .flit_cnt  (flit_cnt),
`endif
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and check helper
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [W-1:0]  exp_q [$];
  logic [FW-1:0] src_q [NS][$];
  logic [NS-1:0] flush_mask = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic hdr, input logic tail, input logic [31:0] pl);
    return {hdr, tail, pl};
  endfunction

  // ---------------------------------------------------------------------------
  // Source driver: pops accepted flits, presents the queue head
  // ---------------------------------------------------------------------------
  logic [NS-1:0] acc;

  initial begin
    inj.src_valid = '0;
    inj.src_flit  = '0;
    forever begin
      @(negedge noc_clk); #4;
      acc = inj.src_valid & inj.src_ready;
      @(posedge noc_clk); #1;
      for (int i = 0; i < NS; i++) begin
        if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (flush_mask[i]) src_q[i].delete();
        if (src_q[i].size() > 0) begin
          inj.src_valid[i]            = 1'b1;
          inj.src_flit[i*FW +: FW]    = src_q[i][0];
        end else begin
          inj.src_valid[i]            = 1'b0;
          inj.src_flit[i*FW +: FW]    = '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Router-side monitor / scoreboard
  // ---------------------------------------------------------------------------
  logic [1:0]   mon_vc;
  logic [W-1:0] mon_got;
  logic [W-1:0] mon_exp;

  initial begin
    forever begin
      @(negedge noc_clk); #4;
      if (noc_rst_n && |(inj.out_valid & inj.out_ready)) begin
        mon_vc = '0;
        for (int v = 0; v < NV; v++) if (inj.out_valid[v]) mon_vc = 2'(v);
        mon_got = {mon_vc, inj.out_flit};
        check("out_valid_onehot", 64'($onehot(inj.out_valid)), 64'd1);
        check("sb_flit_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check("sb_vc_flit", 64'(mon_got), 64'(mon_exp));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed-step helpers
  // ---------------------------------------------------------------------------
  task automatic nxt();
    @(negedge noc_clk); #1;
  endtask

  task automatic push_pkt(input int src, input int vc, input logic [31:0] base, input int len);
    logic [FW-1:0] f;
    for (int k = 0; k < len; k++) begin
      f = mk(k == 0, k == len - 1, base + 32'(k));
      src_q[src].push_back(f);
      exp_q.push_back({2'(vc), f});
    end
  endtask

  task automatic drain(input string tag);
    int k;
    int busy;
    k = 0;
    busy = 1;
    while (busy != 0 && k < 300) begin
      busy = exp_q.size();
      for (int i = 0; i < NS; i++) busy += src_q[i].size();
      if (busy != 0) nxt();
      k++;
    end
    nxt();
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    inj.out_ready = '1;

    // 1: reset state, then quiet outputs for 10 cycles after release
    nxt();
    check("rst_out_valid", 64'(inj.out_valid), 64'd0);
    check("rst_out_flit",  64'(inj.out_flit),  64'd0);
    check("rst_src_ready", 64'(inj.src_ready), 64'd0);
    check("rst_proto_err", 64'(proto_err),     64'd0);
    check("rst_state",     64'(state_dbg),     64'(IDLE));
    noc_rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      nxt();
      check("idle_out_valid", 64'(inj.out_valid), 64'd0);
      check("idle_proto_err", 64'(proto_err),     64'd0);
    end

    // 2: src0 3-flit packet, all VCs ready, rr_ptr=0
    push_pkt(0, 0, 32'hA0, 3);
    nxt();
    check("t2_bubble_state", 64'(state_dbg),     64'(IDLE));
    check("t2_bubble_ready", 64'(inj.src_ready), 64'd0);
    nxt();
    check("t2_fwd_state",    64'(state_dbg),     64'(FWD));
    check("t2_fwd_ready",    64'(inj.src_ready), 64'b0001);
    check("t2_fwd_outv",     64'(inj.out_valid), 64'd0);
    nxt();
    check("t2_hdr_valid",    64'(inj.out_valid), 64'b0001);
    check("t2_hdr_flit",     64'(inj.out_flit),  64'(mk(1'b1, 1'b0, 32'hA0)));
    nxt();
    check("t2_data_flit",    64'(inj.out_flit),  64'(mk(1'b0, 1'b0, 32'hA1)));
    nxt();
    check("t2_tail_flit",    64'(inj.out_flit),  64'(mk(1'b0, 1'b1, 32'hA2)));
    check("t2_back_idle",    64'(state_dbg),     64'(IDLE));
    drain("t2");

    // 3a: src1 and src2 headers together; rr_ptr=1 so src1 goes first
    push_pkt(1, 0, 32'hB0, 2);
    push_pkt(2, 0, 32'hC0, 2);
    nxt();
    nxt();
    check("t3a_lock_src1",   64'(inj.src_ready), 64'b0010);
    drain("t3a");

    // 3b: rr_ptr=3 now; src3 and src0 tie, src3 first
    push_pkt(3, 0, 32'hE0, 1);
    push_pkt(0, 0, 32'hD0, 1);
    nxt();
    nxt();
    check("t3b_lock_src3",   64'(inj.src_ready), 64'b1000);
    drain("t3b");

    // 4: VC0 busy at arbitration -> VC1; stall VC1 mid-packet
    inj.out_ready = 4'b1110;
    push_pkt(1, 1, 32'hF0, 4);
    nxt();
    nxt();
    nxt();
    check("t4_vc1_valid",    64'(inj.out_valid), 64'b0010);
    check("t4_hdr_flit",     64'(inj.out_flit),  64'(mk(1'b1, 1'b0, 32'hF0)));
    inj.out_ready = 4'b1100;
    nxt();
    check("t4_stall_valid",  64'(inj.out_valid), 64'b0010);
    check("t4_stall_flit",   64'(inj.out_flit),  64'(mk(1'b1, 1'b0, 32'hF0)));
    check("t4_stall_ready",  64'(inj.src_ready), 64'd0);
    nxt();
    check("t4_stall2_valid", 64'(inj.out_valid), 64'b0010);
    inj.out_ready = 4'b1110;
    nxt();
    check("t4_resume_flit",  64'(inj.out_flit),  64'(mk(1'b0, 1'b0, 32'hF1)));
    drain("t4");
    inj.out_ready = '1;

    // 5: non-header flit offered by src3 while idle
    check("t5_pre_err",      64'(proto_err),     64'd0);
    src_q[3].push_back(mk(1'b0, 1'b0, 32'h55));
    nxt();
    check("t5_not_yet_err",  64'(proto_err),     64'd0);
    check("t5_no_ready",     64'(inj.src_ready), 64'd0);
    nxt();
    check("t5_err_set",      64'(proto_err),     64'd1);
    check("t5_no_ready2",    64'(inj.src_ready), 64'd0);
    check("t5_no_out",       64'(inj.out_valid), 64'd0);
    nxt();
    check("t5_stay_idle",    64'(state_dbg),     64'(IDLE));
    flush_mask = 4'b1000;
    nxt();
    flush_mask = '0;
    nxt();
    check("t5_err_sticky",   64'(proto_err),     64'd1);

    // 6: reset after the header has left; data flit is dropped
    src_q[0].push_back(mk(1'b1, 1'b0, 32'h70));
    src_q[0].push_back(mk(1'b0, 1'b0, 32'h71));
    src_q[0].push_back(mk(1'b0, 1'b1, 32'h72));
    exp_q.push_back({2'd0, mk(1'b1, 1'b0, 32'h70)});
    nxt();
    nxt();
    nxt();
    check("t6_hdr_out",      64'(inj.out_flit),  64'(mk(1'b1, 1'b0, 32'h70)));
    nxt();
    check("t6_data_in_reg",  64'(inj.out_flit),  64'(mk(1'b0, 1'b0, 32'h71)));
    noc_rst_n  = 1'b0;
    flush_mask = 4'b0001;
    #1;
    check("t6_rst_outv",     64'(inj.out_valid), 64'd0);
    check("t6_rst_state",    64'(state_dbg),     64'(IDLE));
    check("t6_rst_err",      64'(proto_err),     64'd0);
    nxt();
    check("t6_rst_outv2",    64'(inj.out_valid), 64'd0);
    check("t6_rst_ready",    64'(inj.src_ready), 64'd0);
`ifdef NOC_INJ_STATS_EN
    check("t6_pkt_cnt_rst",  64'(pkt_cnt[15:0]), 64'd0);
`endif
    nxt();
    flush_mask = '0;
    noc_rst_n  = 1'b1;
    push_pkt(0, 0, 32'h80, 2);
    nxt();
    check("t6_new_bubble",   64'(state_dbg),     64'(IDLE));
    nxt();
    check("t6_new_ready",    64'(inj.src_ready), 64'b0001);
    nxt();
    check("t6_new_valid",    64'(inj.out_valid), 64'b0001);
    check("t6_new_flit",     64'(inj.out_flit),  64'(mk(1'b1, 1'b0, 32'h80)));
    drain("t6");
`ifdef NOC_INJ_STATS_EN
    check("t6_pkt_cnt_one",  64'(pkt_cnt[15:0]), 64'd1);
    check("t6_flit_cnt",     64'(flit_cnt),      64'd2);
`endif

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    if (n_fail != 0) $display("%0d comparisons did not match", n_fail);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
